fsqrt_issue_ctrl: RTL

- Upstream issue/retire controller for the iterative Newton square-root core (fsqrt_newton).
- Accepts square-root requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the core's operand and start lines, holding them stable for the whole operation, and detects retirement from the core's stall line.
- Captures the result with its tag and presents it downstream on a valid/ready handshake; a watchdog converts a hung operation into an error response.

---
 rtl/fsqrt_issue_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fsqrt_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fsqrt_issue_ctrl
//
// Issue/retire controller that sits upstream of the iterative Newton
// square-root core (fsqrt_newton). Requests are queued in a small FIFO,
// issued one at a time to the core with operand/rounding mode held stable
// while core_fsqrt is high, and retired when the core drops core_stall.
// A watchdog turns a hung operation into an error response (quiet NaN).
//
// Ports:
//   clk, clrn              clock (rising edge), async active-low reset
//   req_valid/ready        request handshake
//   req_d, req_rm, req_tag operand, rounding mode, tag of the request
//   core_d, core_rm        operand / rounding mode to the core (registered)
//   core_fsqrt             start/hold line to the core (high only in RUN)
//   core_stall, core_s     core stall (low = result ready) and result
//   rsp_valid/ready        response handshake
//   rsp_s, rsp_tag         retired result and its tag
//   rsp_err                response produced by the watchdog
//   occupancy              FIFO entry count
//   ops_done               retired-operation counter (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in flight, waiting for a queued request
// RUN   | core_fsqrt high, operand held, waiting for core_stall low
// DONE  | core_fsqrt low (core re-arms), response held until accepted
// ---------------------------------------------------------------------------
module fsqrt_issue_ctrl #(
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_d,
    input  logic [1:0]                 req_rm,
    input  logic [TAG_W-1:0]           req_tag,
    output logic [31:0]                core_d,
    output logic [1:0]                 core_rm,
    output logic                       core_fsqrt,
    input  logic                       core_stall,
    input  logic [31:0]                core_s,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_s,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                ops_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT);
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      fifo_d   [DEPTH];
    logic [1:0]       fifo_rm  [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [TO_W-1:0]  run_cnt;
    logic [TAG_W-1:0] cur_tag;

    logic push;
    logic pop;
    logic retire_ok;
    logic retire_wd;
    logic accept;

    // Full is judged on the registered count only: a pop in the same cycle
    // does not open a slot until the next cycle.
    always_comb begin
        req_ready = (occupancy != FULL);
        push      = req_valid && req_ready;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        retire_ok  = 1'b0;
        retire_wd  = 1'b0;
        accept     = 1'b0;
        core_fsqrt = 1'b0;
        case (state)
            IDLE: begin
                if (occupancy != '0) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                core_fsqrt = 1'b1;
                // The core's stall output is not yet valid in the first
                // RUN cycle, so a low stall there is ignored.
                if ((run_cnt != '0) && !core_stall) begin
                    retire_ok = 1'b1;
                    state_nxt = DONE;
                end else if (run_cnt == TO_LAST) begin
                    retire_wd = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    accept = 1'b1;
                    if (occupancy != '0) begin
                        pop       = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[wr_ptr]   <= req_d;
            fifo_rm[wr_ptr]  <= req_rm;
            fifo_tag[wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Operand/rounding mode only change on a pop, so they are stable for the
    // whole RUN period.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            core_d  <= '0;
            core_rm <= '0;
            cur_tag <= '0;
        end else if (pop) begin
            core_d  <= fifo_d[rd_ptr];
            core_rm <= fifo_rm[rd_ptr];
            cur_tag <= fifo_tag[rd_ptr];
        end
    end

    // Cleared outside RUN so it reads 0 in the first cycle of every RUN.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            run_cnt <= '0;
        end else if (state != RUN) begin
            run_cnt <= '0;
        end else if (run_cnt != TO_LAST) begin
            run_cnt <= run_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rsp_valid <= 1'b0;
            rsp_s     <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (retire_ok || retire_wd) begin
                rsp_valid <= 1'b1;
                rsp_s     <= retire_ok ? core_s : QNAN;
                rsp_tag   <= cur_tag;
                rsp_err   <= retire_wd;
                ops_done  <= ops_done + 16'd1;
            end else if (accept) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
